tinyalu_core: RTL and testbench
===============================

Name: tinyalu_core

Overview:
- Responder end of the TinyALU start/done command interface: the arithmetic unit the BFM drives and the scoreboard checks.
- Samples a command (op, A, B) when start is seen, then executes it. Single-cycle ops take one clock; mul uses a latency counter.
- Returns a 16-bit result with a one-cycle done pulse.
- Sits as the DUT under the tinyalu_bfm interface.

Parameters:
- DATA_W, 8, operand width; result width is 2*DATA_W.
- MUL_LATENCY, 3, clock edges from command capture to done for mul_op; legal range 2..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- A  input  DATA_W  operand A, unsigned.
- B  input  DATA_W  operand B, unsigned.
- op  input  3  opcode: 000 no_op, 001 add_op, 010 and_op, 011 xor_op, 100 mul_op; 101/110/111 reserved.
- start  input  1  command request; driver holds it high until done is seen.
- done  output  1  one-cycle pulse; result is valid while done=1 and holds after.
- result  output  2*DATA_W  operation result, registered.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, done=0, result=0, latency counter=0, operand registers=0. Takes effect immediately, including mid-operation; an aborted command never produces done.
- States: IDLE, EXEC, DONE, WAIT_LOW.
- IDLE: at edge k with start=1, capture op, A and B into registers.
  - Single-cycle ops (no_op, add, and, xor, reserved) go to DONE.
  - mul goes to EXEC with counter loaded to MUL_LATENCY-1.
  - With start=0, stay in IDLE.
- EXEC: counter decrements each edge; at counter==1 go to DONE.
- DONE timing:
  - Single-cycle ops: done=1 and result written at edge k+1.
  - mul: done=1 and result written at edge k+MUL_LATENCY.
  - done drops at the following edge. Exactly one done per command.
- WAIT_LOW: entered after DONE. Stay while start=1; go to IDLE at the first edge sampling start=0. Prevents re-triggering on a held start.
- Input changes: op, A and B changes after capture edge k are ignored. start=0 during EXEC does not abort the command.
- Arithmetic (all unsigned, zero-extended to 2*DATA_W):
  - add: 9-bit sum with carry in bit DATA_W.
  - and, xor: upper DATA_W bits are 0.
  - mul: full 2*DATA_W product.
- no_op and reserved opcodes: done pulses at k+1 and result keeps its previous value.
- done never asserts while state is IDLE or WAIT_LOW.
- Back-to-back commands: the earliest next capture is the edge after WAIT_LOW exits. Minimum command period for a single-cycle op is 3 edges (capture, done, start-low).

Test Plan:
- Reset release, start=0 for 5 cycles -> done=0 and result=0x0000 throughout.
- add A=0xFF B=0xFF, start at edge k -> done=1 only in cycle after edge k+1, result=0x01FE.
- xor A=0xA5 B=0x0F -> result=0x00AA. Then and A=0xF0 B=0x3C -> result=0x0030. Each done lasts exactly one cycle.
- mul A=0xFF B=0xFF, change A to 0x00 after capture -> done at edge k+3 (MUL_LATENCY=3), result=0xFE01.
- Hold start=1 for 10 cycles after an add completes -> exactly one done pulse. Drop start for 1 cycle, then reassert with op=no_op -> done pulse, result still 0x01FE. op=3'b110 -> same as no_op.
- Start mul A=0x10 B=0x10, assert reset_n=0 at edge k+1 -> done stays 0 and result=0x0000 immediately. After release, a new add 0x01+0x02 -> result=0x0003.

Source files
------------

// File: rtl/tinyalu_core.sv
// -----------------------------------------------------------------------------
// tinyalu_core
//
// Responder end of the TinyALU start/done command interface. A command
// (op, A, B) is captured on the first rising edge that sees start=1 while the
// unit is idle. The command is then executed and the registered result is
// returned together with a one-cycle done pulse.
//
// Handshake: the requester raises start with a stable op/A/B and holds start
// high until it sees done=1. The unit captures op/A/B on the first edge that
// samples start=1 in IDLE. done is high for exactly one cycle per captured
// command. After that the unit waits for start to be seen low before it
// accepts another command, so a held start never re-triggers.
//
// Ports
//   clk          in   1         system clock, rising edge
//   reset_n      in   1         asynchronous active-low reset
//   A            in   DATA_W    operand A, unsigned
//   B            in   DATA_W    operand B, unsigned
//   op           in   3         000 no_op, 001 add, 010 and, 011 xor, 100 mul,
//                               101/110/111 reserved (behave as no_op)
//   start        in   1         command request
//   done         out  1         one-cycle completion pulse
//   result       out  2*DATA_W  registered result, holds after done
//   dbg_state_o  out  2         current FSM state (debug observation only)
//
// Timing, with capture at edge k:
//   single-cycle ops  done/result at edge k+1
//   mul               done/result at edge k+MUL_LATENCY
// The FSM sits in DONE during the cycle before the done edge. On that edge
// result and done are written together and the FSM moves on to WAIT_LOW.
// -----------------------------------------------------------------------------
module tinyalu_core #(
    parameter int DATA_W      = 8,
    parameter int MUL_LATENCY = 3    // legal range 2..15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   A,
    input  logic [DATA_W-1:0]   B,
    input  logic [2:0]          op,
    input  logic                start,
    output logic                done,
    output logic [2*DATA_W-1:0] result,
    output logic [1:0]          dbg_state_o
);

    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_DONE     = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t              state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [2:0]          op_q,     op_d;
    logic [DATA_W-1:0]   a_q,      a_d;
    logic [DATA_W-1:0]   b_q,      b_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                done_q,   done_d;

    // Value the ALU would produce for the captured command. For no_op and the
    // reserved opcodes this is the current result, so the result holds.
    logic [RES_W-1:0]    alu_res;

    // -------------------------------------------------------------------------
    // ALU: all operands zero-extended to the full result width first. This
    // keeps the add carry in bit DATA_W and gives the full-width product.
    // -------------------------------------------------------------------------
    always_comb begin
        alu_res = result_q;
        case (op_q)
            OP_ADD:  alu_res = RES_W'(a_q) + RES_W'(b_q);
            OP_AND:  alu_res = RES_W'(a_q & b_q);
            OP_XOR:  alu_res = RES_W'(a_q ^ b_q);
            OP_MUL:  alu_res = RES_W'(a_q) * RES_W'(b_q);
            default: alu_res = result_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Later changes to op/A/B do not affect this command,
                    // because only these registers are used from here on.
                    op_d = op;
                    a_d  = A;
                    b_d  = B;
                    if (op == OP_MUL) begin
                        // Entering DONE at cnt==1 puts the done edge at
                        // exactly k+MUL_LATENCY.
                        state_d = S_EXEC;
                        cnt_d   = CNT_W'(MUL_LATENCY - 1);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_EXEC: begin
                // start is deliberately ignored here: dropping it does not
                // abort the command.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                result_d = alu_res;
                done_d   = 1'b1;
                state_d  = S_WAIT_LOW;
            end

            S_WAIT_LOW: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register. Reset is asynchronous, so a command in flight is
    // discarded at once and never produces done.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign done        = done_q;
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tinyalu_core.sv
module tb_tinyalu_core;

    localparam int DATA_W      = 8;
    localparam int MUL_LATENCY = 3;
    localparam int RES_W       = 2 * DATA_W;
    localparam int BUDGET      = 40;

    logic              clk;
    logic              reset_n;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
    logic              start;
    logic              done;
    logic [RES_W-1:0]  result;
    logic [1:0]        dbg_state;

    int n_cmp;
    int n_err;

    tinyalu_core #(
        .DATA_W      (DATA_W),
        .MUL_LATENCY (MUL_LATENCY)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .A           (a),
        .B           (b),
        .op          (op),
        .start       (start),
        .done        (done),
        .result      (result),
        .dbg_state_o (dbg_state)
    );

    // ------------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Issue one command. Start is raised #1 after a rising edge, so the next
    // edge is the capture edge k. The task checks the edge count from k to
    // done, the result, and that done falls one cycle later. When drop_start
    // is 0, start stays high after done.
    // ------------------------------------------------------------------------
    task automatic do_cmd(input logic [2:0] c_op, input logic [DATA_W-1:0] c_a,
                          input logic [DATA_W-1:0] c_b, input logic [RES_W-1:0] exp_res,
                          input int exp_lat, input bit drop_start, input string name);
        int lat;
        lat = 0;
        op    = c_op;
        a     = c_a;
        b     = c_b;
        start = 1'b1;
        @(posedge clk);                 // edge k: capture
        #1;
        for (int n = 1; n <= BUDGET; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d edges, expected %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (result !== exp_res) begin
            n_err++;
            $display("FAIL %s result: got 0x%04h, expected 0x%04h", name, result, exp_res);
        end
        if (drop_start) start = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_width: done=%b one cycle after pulse, expected 0", name, done);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b0 || result !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: done=%b result=0x%04h, expected done=0 result=0x0000",
                         i, done, result);
            end
        end
        n_cmp++;
        if (dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d, expected 0 (IDLE)", dbg_state);
        end
    endtask

    task automatic test_add();
        do_cmd(3'b001, 8'hFF, 8'hFF, 16'h01FE, 1, 1'b1, "add_ff_ff");
    endtask

    task automatic test_logic();
        do_cmd(3'b011, 8'hA5, 8'h0F, 16'h00AA, 1, 1'b1, "xor_a5_0f");
        do_cmd(3'b010, 8'hF0, 8'h3C, 16'h0030, 1, 1'b1, "and_f0_3c");
    endtask

    // The operand changes after capture must not reach the multiplier.
    task automatic test_mul();
        int lat;
        lat   = 0;
        op    = 3'b100;
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(posedge clk);                 // edge k
        #1;
        a = 8'h00;
        for (int n = 1; n <= BUDGET; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        n_cmp++;
        if (lat !== MUL_LATENCY) begin
            n_err++;
            $display("FAIL mul_latency: got %0d edges, expected %0d", lat, MUL_LATENCY);
        end
        n_cmp++;
        if (result !== 16'hFE01) begin
            n_err++;
            $display("FAIL mul_result: got 0x%04h, expected 0xFE01", result);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL mul_done_width: done=%b, expected 0", done);
        end
    endtask

    task automatic test_hold_start();
        int pulses;
        // The add pulse itself is checked by do_cmd; start stays high afterwards.
        do_cmd(3'b001, 8'hFF, 8'hFF, 16'h01FE, 1, 1'b0, "add_hold");
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL hold_retrigger: got %0d extra done pulses, expected 0", pulses);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        do_cmd(3'b000, 8'h12, 8'h34, 16'h01FE, 1, 1'b1, "no_op_keep");
        do_cmd(3'b110, 8'h56, 8'h78, 16'h01FE, 1, 1'b1, "reserved_110");
    endtask

    task automatic test_reset_mid_mul();
        int pulses;
        op    = 3'b100;
        a     = 8'h10;
        b     = 8'h10;
        start = 1'b1;
        @(posedge clk);                 // edge k
        @(posedge clk);                 // edge k+1
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0 || result !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_mid_mul: done=%b result=0x%04h, expected done=0 result=0x0000",
                     done, result);
        end
        start = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || result !== 16'h0000) begin
            n_err++;
            $display("FAIL aborted_mul: %0d done pulses result=0x%04h, expected 0 pulses result=0x0000",
                     pulses, result);
        end
        do_cmd(3'b001, 8'h01, 8'h02, 16'h0003, 1, 1'b1, "add_after_reset");
    endtask

    // ------------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------------
    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        a       = '0;
        b       = '0;

        test_reset();
        test_add();
        test_logic();
        test_mul();
        test_hold_start();
        test_reset_mid_mul();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
